// File: rtl/mvm_sched.sv
// mvm_sched: walks a command of N weights through a single MVM instance.
// Each weight is fetched from the weight stream, launched with a one-cycle
// start pulse, and its lane counters are captured on the first idle cycle.
// Results leave either per weight or as one saturating per-lane sum.
module mvm_sched #(
    parameter int NUM_BIT = 8,
    parameter int DIM     = 4,
    parameter int CNT_BIT = 5,
    parameter int TIMEOUT = 1023
) (
    input  logic                   i_clk_udc,
    input  logic                   i_rst_udc,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [CNT_BIT-1:0]     i_cmd_n,
    input  logic                   i_cmd_acc,
    input  logic                   i_w_valid,
    output logic                   o_w_ready,
    input  logic [NUM_BIT-1:0]     i_w_data,
    output logic                   o_mvm_start,
    output logic [NUM_BIT-1:0]     o_mvm_w,
    input  logic                   i_mvm_busy,
    input  logic [DIM*NUM_BIT-1:0] i_mvm_result,
    output logic                   o_res_valid,
    input  logic                   i_res_ready,
    output logic [DIM*NUM_BIT-1:0] o_res_data,
    output logic [CNT_BIT-1:0]     o_res_idx,
    output logic                   o_res_last,
    output logic                   o_err,
    input  logic                   i_clr_err
);

    // Watchdog is wide enough to count one past TIMEOUT without wrapping.
    localparam int WD_W = $clog2(TIMEOUT + 2);
    localparam logic [WD_W-1:0] WD_RUN_LAST  = WD_W'(TIMEOUT - 1);
    // Watchdog value in the last WAIT_HI cycle before giving up on busy.
    localparam logic [WD_W-1:0] WD_WAIT_LAST = WD_W'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAUNCH,
        S_WAIT_HI,
        S_RUN,
        S_EMIT,
        S_ERR
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_BIT-1:0]     n_reg;
    logic                   acc_mode_reg;
    logic [CNT_BIT-1:0]     idx_reg;
    logic [DIM*NUM_BIT-1:0] accum_reg;
    logic [WD_W-1:0]        wd_reg;
    logic                   start_reg;
    logic [NUM_BIT-1:0]     w_reg;
    logic                   res_valid_reg;
    logic [DIM*NUM_BIT-1:0] res_data_reg;
    logic [CNT_BIT-1:0]     res_idx_reg;
    logic                   res_last_reg;
    logic                   err_reg;

    logic                   cmd_fire;
    logic                   w_fire;
    logic                   pass_done;
    logic                   res_fire;
    logic                   idx_is_last;
    logic [DIM*NUM_BIT-1:0] sat_sum;

    assign cmd_fire    = (state_reg == S_IDLE) && i_cmd_valid;
    assign w_fire      = (state_reg == S_FETCH) && i_w_valid;
    assign pass_done   = (state_reg == S_RUN) && !i_mvm_busy;
    assign res_fire    = (state_reg == S_EMIT) && i_res_ready;
    assign idx_is_last = (idx_reg == n_reg - CNT_BIT'(1));

    // Per-lane saturating add of the live MVM counters into the accumulator;
    // it must use i_mvm_result directly since the counters clear next edge.
    genvar gi;
    generate
        for (gi = 0; gi < DIM; gi++) begin : g_lane
            logic [NUM_BIT:0] lane_sum;
            assign lane_sum = {1'b0, accum_reg[gi*NUM_BIT +: NUM_BIT]}
                            + {1'b0, i_mvm_result[gi*NUM_BIT +: NUM_BIT]};
            assign sat_sum[gi*NUM_BIT +: NUM_BIT] =
                lane_sum[NUM_BIT] ? {NUM_BIT{1'b1}} : lane_sum[NUM_BIT-1:0];
        end
    endgenerate

    // State register.
    always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
        if (i_rst_udc) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    state_next = (i_cmd_n == '0) ? S_EMIT : S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_w_valid) begin
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_next = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (i_mvm_busy) begin
                    state_next = S_RUN;
                end else if (wd_reg == WD_WAIT_LAST) begin
                    state_next = S_ERR;
                end
            end
            S_RUN: begin
                if (!i_mvm_busy) begin
                    if (!acc_mode_reg || idx_is_last) begin
                        state_next = S_EMIT;
                    end else begin
                        state_next = S_FETCH;
                    end
                end else if (wd_reg == WD_RUN_LAST) begin
                    state_next = S_ERR;
                end
            end
            S_EMIT: begin
                if (i_res_ready) begin
                    if (acc_mode_reg || res_last_reg) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_ERR: begin
                if (i_clr_err) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Command context: weight count, mode, running index and accumulator.
    always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
        if (i_rst_udc) begin
            n_reg        <= '0;
            acc_mode_reg <= 1'b0;
            idx_reg      <= '0;
            accum_reg    <= '0;
        end else if (cmd_fire) begin
            n_reg        <= i_cmd_n;
            acc_mode_reg <= i_cmd_acc;
            idx_reg      <= '0;
            accum_reg    <= '0;
        end else begin
            if (pass_done && acc_mode_reg) begin
                accum_reg <= sat_sum;
            end
            if ((pass_done && acc_mode_reg && !idx_is_last) ||
                (res_fire && !acc_mode_reg && !res_last_reg)) begin
                idx_reg <= idx_reg + CNT_BIT'(1);
            end
        end
    end

    // Weight hold and start pulse; start is high exactly while in LAUNCH.
    always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
        if (i_rst_udc) begin
            w_reg     <= '0;
            start_reg <= 1'b0;
        end else begin
            if (w_fire) begin
                w_reg <= i_w_data;
            end
            start_reg <= (state_next == S_LAUNCH);
        end
    end

    // Pass watchdog: zero in LAUNCH, counts through WAIT_HI and RUN.
    always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
        if (i_rst_udc) begin
            wd_reg <= '0;
        end else if (state_next == S_LAUNCH) begin
            wd_reg <= '0;
        end else if (state_reg inside {S_LAUNCH, S_WAIT_HI, S_RUN}) begin
            wd_reg <= wd_reg + WD_W'(1);
        end
    end

    // Result register, loaded on entry to EMIT and held while stalled.
    always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
        if (i_rst_udc) begin
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_idx_reg   <= '0;
            res_last_reg  <= 1'b0;
        end else begin
            res_valid_reg <= (state_next == S_EMIT);
            if (cmd_fire && (i_cmd_n == '0)) begin
                res_data_reg <= '0;
                res_idx_reg  <= '0;
                res_last_reg <= 1'b1;
            end else if (pass_done && (!acc_mode_reg || idx_is_last)) begin
                res_data_reg <= acc_mode_reg ? sat_sum : i_mvm_result;
                res_idx_reg  <= idx_reg;
                res_last_reg <= acc_mode_reg || idx_is_last;
            end
        end
    end

    // Sticky error flag, high for as long as the sequencer sits in ERR.
    always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
        if (i_rst_udc) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= (state_next == S_ERR);
        end
    end

    assign o_cmd_ready = (state_reg == S_IDLE);
    assign o_w_ready   = (state_reg == S_FETCH);
    assign o_mvm_start = start_reg;
    assign o_mvm_w     = w_reg;
    assign o_res_valid = res_valid_reg;
    assign o_res_data  = res_data_reg;
    assign o_res_idx   = res_idx_reg;
    assign o_res_last  = res_last_reg;
    assign o_err       = err_reg;

endmodule
